// File: rtl/block_mem_responder.sv
// Block-organised backing store behind the L1 cache block interface: serves one level-held
// block read or write at a time and reports completion with a one-cycle valid pulse after a fixed latency.
module block_mem_responder #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned BLOCK_W   = 256,
   parameter int unsigned IDX_W     = 10,
   parameter int unsigned READ_LAT  = 4,
   parameter int unsigned WRITE_LAT = 4
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic [ADDR_W-1:0]  mem_address,
   input  logic               blk_read,
   input  logic               blk_write,
   input  logic [BLOCK_W-1:0] block_write_data,
   output logic [BLOCK_W-1:0] block_read_data,
   output logic               block_read_valid,
   output logic               block_write_valid,
   output logic               busy
);

   localparam int unsigned MAX_LAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
   localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
   localparam int unsigned DEPTH   = 1 << IDX_W;

   typedef enum logic [1:0] {
      IDLE,
      RD_WAIT,
      WR_WAIT,
      DONE
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [BLOCK_W-1:0] wdata_q, wdata_d;
   logic [BLOCK_W-1:0] rdata_q, rdata_d;
   logic               rvalid_q, rvalid_d;
   logic               wvalid_q, wvalid_d;
   logic               mem_we;

   logic [BLOCK_W-1:0] store_q [DEPTH];

   logic [IDX_W-1:0]   req_idx;
   logic               unused_addr;

   // Offset bits and bits above the index do not select a block.
   assign req_idx     = mem_address[5 +: IDX_W];
   assign unused_addr = ^{mem_address[ADDR_W-1:5+IDX_W], mem_address[4:0]};

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      wvalid_d = 1'b0;
      mem_we   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (blk_write) begin
               idx_d   = req_idx;
               wdata_d = block_write_data;
               cnt_d   = CNT_W'(WRITE_LAT - 1);
               state_d = WR_WAIT;
            end else if (blk_read) begin
               idx_d   = req_idx;
               cnt_d   = CNT_W'(READ_LAT - 1);
               state_d = RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (!blk_read) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               rdata_d  = store_q[idx_q];
               rvalid_d = 1'b1;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WR_WAIT: begin
            if (!blk_write) begin
               state_d = IDLE;
            end else if (cnt_q == '0) begin
               mem_we   = 1'b1;
               wvalid_d = 1'b1;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            // Hold here while either request is still up so it is not served twice.
            if (!blk_read && !blk_write) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         idx_q    <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         wvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
         wvalid_q <= wvalid_d;
      end
   end

   // Backing store is deliberately left out of reset.
   always_ff @(posedge CLK) begin
      if (mem_we) begin
         store_q[idx_q] <= wdata_q;
      end
   end

   assign block_read_data   = rdata_q;
   assign block_read_valid  = rvalid_q;
   assign block_write_valid = wvalid_q;
   assign busy              = (state_q != IDLE);

endmodule

// File: tb/tb_block_mem_responder.sv
// Directed self-checking bench for block_mem_responder: reset, latency, aliasing,
// write priority, abort and held-request behaviour with hand-computed expectations.
module tb_block_mem_responder;

   logic         CLK;
   logic         RESET;
   logic [31:0]  mem_address;
   logic         blk_read;
   logic         blk_write;
   logic [255:0] block_write_data;
   logic [255:0] block_read_data;
   logic         block_read_valid;
   logic         block_write_valid;
   logic         busy;

   int tests = 0;
   int fails = 0;

   localparam logic [255:0] PAT_A5 = {32{8'hA5}};
   localparam logic [255:0] PAT_11 = {32{8'h11}};
   localparam logic [255:0] PAT_22 = {32{8'h22}};
   localparam logic [255:0] PAT_33 = {32{8'h33}};
   localparam logic [255:0] PAT_D1 = {8{32'hDEAD_0001}};

   block_mem_responder dut (
      .CLK              (CLK),
      .RESET            (RESET),
      .mem_address      (mem_address),
      .blk_read         (blk_read),
      .blk_write        (blk_write),
      .block_write_data (block_write_data),
      .block_read_data  (block_read_data),
      .block_read_valid (block_read_valid),
      .block_write_valid(block_write_valid),
      .busy             (busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Full write transaction; address/data are scrambled after acceptance to prove latching.
   task automatic do_write(input string tag, input logic [31:0] a, input logic [255:0] d);
      mem_address      = a;
      block_write_data = d;
      blk_write        = 1'b1;
      tick();
      chk({tag, "_busy"}, 256'(busy), 256'(1));
      mem_address      = ~a;
      block_write_data = ~d;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk({tag, "_wv_early"}, 256'(block_write_valid), 256'(0));
      end
      tick();
      chk({tag, "_wv"}, 256'(block_write_valid), 256'(1));
      blk_write = 1'b0;
      tick();
      chk({tag, "_wv_off"}, 256'(block_write_valid), 256'(0));
      chk({tag, "_idle"}, 256'(busy), 256'(0));
   endtask

   task automatic do_read(input string tag, input logic [31:0] a, input logic [255:0] exp);
      mem_address = a;
      blk_read    = 1'b1;
      tick();
      chk({tag, "_busy"}, 256'(busy), 256'(1));
      mem_address = ~a;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk({tag, "_rv_early"}, 256'(block_read_valid), 256'(0));
      end
      tick();
      chk({tag, "_rv"}, 256'(block_read_valid), 256'(1));
      chk({tag, "_data"}, block_read_data, exp);
      blk_read = 1'b0;
      tick();
      chk({tag, "_rv_off"}, 256'(block_read_valid), 256'(0));
      chk({tag, "_idle"}, 256'(busy), 256'(0));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      RESET            = 1'b0;
      blk_read         = 1'b0;
      blk_write        = 1'b0;
      mem_address      = '0;
      block_write_data = '0;
      tick();
      tick();
      chk("rst_busy", 256'(busy), 256'(0));
      chk("rst_rv", 256'(block_read_valid), 256'(0));
      chk("rst_wv", 256'(block_write_valid), 256'(0));
      chk("rst_rdata", block_read_data, '0);
      #2 RESET = 1'b1;
      tick();

      // Write then read of the same block
      do_write("wr40", 32'h40, PAT_A5);
      do_read("rd40", 32'h40, PAT_A5);

      // Reset asserted during RD_WAIT drops the request and clears read data
      mem_address = 32'h40;
      blk_read    = 1'b1;
      tick();
      tick();
      chk("mid_busy_pre", 256'(busy), 256'(1));
      RESET = 1'b0;
      #1;
      chk("mid_busy", 256'(busy), 256'(0));
      chk("mid_rv", 256'(block_read_valid), 256'(0));
      chk("mid_wv", 256'(block_write_valid), 256'(0));
      chk("mid_rdata", block_read_data, '0);
      tick();
      #2 RESET = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_restart_early", 256'(block_read_valid), 256'(0));
      end
      tick();
      chk("rst_restart_rv", 256'(block_read_valid), 256'(1));
      chk("rst_restart_data", block_read_data, PAT_A5);
      blk_read = 1'b0;
      tick();
      chk("rst_restart_idle", 256'(busy), 256'(0));

      // Offset and upper address bits alias onto index 0x80
      do_write("wr1000", 32'h1000, PAT_D1);
      do_read("rd101c", 32'h101C, PAT_D1);
      do_read("rd9000", 32'h0000_9000, PAT_D1);

      // Simultaneous request: write wins, read returns the new data afterwards
      do_write("wr60", 32'h60, PAT_11);
      mem_address      = 32'h60;
      block_write_data = PAT_22;
      blk_read         = 1'b1;
      blk_write        = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("both_wv_early", 256'(block_write_valid), 256'(0));
      end
      tick();
      chk("both_wv", 256'(block_write_valid), 256'(1));
      chk("both_rv", 256'(block_read_valid), 256'(0));
      chk("both_rdata_kept", block_read_data, PAT_D1);
      blk_read  = 1'b0;
      blk_write = 1'b0;
      tick();
      chk("both_idle", 256'(busy), 256'(0));
      do_read("rd60", 32'h60, PAT_22);

      // Read aborted at +2: no pulse, data untouched
      mem_address = 32'h40;
      blk_read    = 1'b1;
      tick();
      tick();
      tick();
      blk_read = 1'b0;
      tick();
      chk("abort_busy", 256'(busy), 256'(0));
      chk("abort_rv", 256'(block_read_valid), 256'(0));
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("abort_rv_late", 256'(block_read_valid), 256'(0));
      end
      chk("abort_rdata", block_read_data, PAT_22);

      // Write aborted at +2 must not update the store
      mem_address      = 32'h60;
      block_write_data = PAT_33;
      blk_write        = 1'b1;
      tick();
      tick();
      tick();
      blk_write = 1'b0;
      tick();
      chk("wabort_busy", 256'(busy), 256'(0));
      chk("wabort_wv", 256'(block_write_valid), 256'(0));
      do_read("rd60_after_abort", 32'h60, PAT_22);

      // Held read: single pulse, FSM parked in DONE until release
      mem_address = 32'h1000;
      blk_read    = 1'b1;
      pulses      = 0;
      tick();
      for (int i = 0; i < 7; i++) begin
         tick();
         if (block_read_valid) pulses++;
      end
      chk("held_pulses", 256'(pulses), 256'(1));
      chk("held_busy", 256'(busy), 256'(1));
      chk("held_data", block_read_data, PAT_D1);
      blk_read = 1'b0;
      tick();
      chk("held_release", 256'(busy), 256'(0));
      chk("held_rv_off", 256'(block_read_valid), 256'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
